// File: rtl/exec_mul_ctrl_if.sv
// rtl/exec_mul_ctrl_if.sv - exec-stage to sequential multiplier handshake bundle
interface exec_mul_ctrl_if #(
   parameter int REG_SIZE = 32
);
   logic                req;
   logic [4:0]          aluop;
   logic [REG_SIZE-1:0] src1;
   logic [REG_SIZE-1:0] src2;
   logic                flush;
   logic                stall;
   logic                busy;
   logic                done;
   logic [REG_SIZE-1:0] result;
   logic                overflow;

   modport master (
      output req, aluop, src1, src2, flush,
      input  stall, busy, done, result, overflow
   );

   modport slave (
      input  req, aluop, src1, src2, flush,
      output stall, busy, done, result, overflow
   );
endinterface

// File: rtl/exec_mul_ctrl.sv
// rtl/exec_mul_ctrl.sv - iterative signed shift-add multiplier with pipeline stall control
`ifndef ALUOP_MUL
`define ALUOP_MUL 5'd10
`endif

module exec_mul_ctrl #(
   parameter int         REG_SIZE  = 32,
   parameter logic [4:0] ALUOP_MUL = `ALUOP_MUL
) (
   input logic            clk,
   input logic            reset,
   exec_mul_ctrl_if.slave mul
);
   localparam int CW = $clog2(REG_SIZE) + 1;
   localparam int PW = 2 * REG_SIZE;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              r_state;
   logic [PW-1:0]       r_mcand;
   logic [PW-1:0]       r_acc;
   logic [REG_SIZE-1:0] r_mplier;
   logic [REG_SIZE-1:0] r_result;
   logic [CW-1:0]       r_cnt;
   logic                r_sign;
   logic                r_busy;
   logic                r_done;
   logic                r_overflow;

   logic                w_accept;
   logic                w_last;
   logic [REG_SIZE-1:0] w_abs1;
   logic [REG_SIZE-1:0] w_abs2;
   logic [PW-1:0]       w_acc_next;
   logic [PW-1:0]       w_prod;

   assign w_accept = (r_state == IDLE) && mul.req && (mul.aluop == ALUOP_MUL) && !mul.flush;

   // Magnitudes are unsigned, so the most negative operand keeps its full value.
   assign w_abs1 = mul.src1[REG_SIZE-1] ? -mul.src1 : mul.src1;
   assign w_abs2 = mul.src2[REG_SIZE-1] ? -mul.src2 : mul.src2;

   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_prod     = r_sign ? -w_acc_next : w_acc_next;
   assign w_last     = (r_cnt == CW'(REG_SIZE - 1));

   assign mul.stall    = !reset && (w_accept || ((r_state == RUN) && !mul.flush));
   assign mul.busy     = r_busy;
   assign mul.done     = r_done;
   assign mul.result   = r_result;
   assign mul.overflow = r_overflow;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_mcand    <= '0;
         r_acc      <= '0;
         r_mplier   <= '0;
         r_result   <= '0;
         r_cnt      <= '0;
         r_sign     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_mcand  <= {{REG_SIZE{1'b0}}, w_abs1};
                  r_mplier <= w_abs2;
                  r_sign   <= mul.src1[REG_SIZE-1] ^ mul.src2[REG_SIZE-1];
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= RUN;
               end
            end
            RUN: begin
               if (mul.flush) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_acc    <= w_acc_next;
                  r_mcand  <= r_mcand << 1;
                  r_mplier <= r_mplier >> 1;
                  r_cnt    <= r_cnt + 1'b1;
                  // Final partial product is folded in directly so DONE holds the full result.
                  if (w_last) begin
                     r_result   <= w_prod[REG_SIZE-1:0];
                     r_overflow <= (w_prod[PW-1:REG_SIZE] != {REG_SIZE{w_prod[REG_SIZE-1]}});
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                     r_state    <= DONE;
                  end
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_exec_mul_ctrl.sv
// tb/tb_exec_mul_ctrl.sv - directed self-checking bench for exec_mul_ctrl
module tb_exec_mul_ctrl;
   localparam logic [4:0] OP_MUL = 5'd10;
   localparam logic [4:0] OP_ADD = 5'd0;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   exec_mul_ctrl_if #(.REG_SIZE(32)) bus ();

   exec_mul_ctrl #(.REG_SIZE(32), .ALUOP_MUL(OP_MUL)) dut (
      .clk   (clk),
      .reset (reset),
      .mul   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      reset = 1'b1;
      bus.req = 1'b1; bus.aluop = OP_MUL; bus.src1 = 32'd7; bus.src2 = 32'd6; bus.flush = 1'b0;
      @(negedge clk); #1;
      total++;
      if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
      repeat (2) @(negedge clk);
      #1;
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      total++;
      if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
      total++;
      if (bus.result !== 32'd0) begin bad++; $display("FAIL reset_result: got %h want 0", bus.result); end
      total++;
      if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
      reset = 1'b0;
      bus.req = 1'b0;
   endtask

   task automatic test_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic ov, input string name);
      @(negedge clk);
      bus.flush = 1'b0; bus.req = 1'b1; bus.aluop = OP_MUL; bus.src1 = a; bus.src2 = b;
      #1;
      total++;
      if (bus.stall !== 1'b1 || bus.busy !== 1'b0)
         begin bad++; $display("FAIL %s_accept: got stall=%b busy=%b want stall=1 busy=0", name, bus.stall, bus.busy); end
      for (int k = 1; k <= 32; k++) begin
         @(negedge clk);
         bus.req = 1'b0; bus.src1 = ~a; bus.src2 = 32'h5A5A_5A5A;
         #1;
         total++;
         if (bus.stall !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0)
            begin bad++; $display("FAIL %s_run%0d: got stall=%b busy=%b done=%b want 1 1 0", name, k, bus.stall, bus.busy, bus.done); end
      end
      @(negedge clk); #1;
      total++;
      if (bus.done !== 1'b1 || bus.stall !== 1'b0 || bus.busy !== 1'b0)
         begin bad++; $display("FAIL %s_done: got done=%b stall=%b busy=%b want 1 0 0", name, bus.done, bus.stall, bus.busy); end
      total++;
      if (bus.result !== res) begin bad++; $display("FAIL %s_result: got %h want %h", name, bus.result, res); end
      total++;
      if (bus.overflow !== ov) begin bad++; $display("FAIL %s_overflow: got %b want %b", name, bus.overflow, ov); end
      @(negedge clk); #1;
      total++;
      if (bus.done !== 1'b0) begin bad++; $display("FAIL %s_pulse: got done=%b want 0", name, bus.done); end
   endtask

   task automatic test_flush();
      @(negedge clk);
      bus.req = 1'b1; bus.aluop = OP_MUL; bus.src1 = 32'd100; bus.src2 = 32'd100; bus.flush = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         bus.req = 1'b0;
         if (k == 10) bus.flush = 1'b1;
      end
      #1;
      total++;
      if (bus.stall !== 1'b0 || bus.busy !== 1'b1)
         begin bad++; $display("FAIL flush_cycle: got stall=%b busy=%b want stall=0 busy=1", bus.stall, bus.busy); end
      @(posedge clk); #1;
      bus.flush = 1'b0;
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0)
         begin bad++; $display("FAIL flush_idle: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
      total++;
      if (bus.result !== 32'h7FFF_FFFF || bus.overflow !== 1'b0)
         begin bad++; $display("FAIL flush_keep: got %h/%b want 7fffffff/0", bus.result, bus.overflow); end
      test_mul(32'd2, 32'd3, 32'd6, 1'b0, "post_flush");
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      bus.req = 1'b1; bus.aluop = OP_MUL; bus.src1 = 32'd9; bus.src2 = 32'd9;
      repeat (5) @(negedge clk);
      reset = 1'b1; bus.flush = 1'b1;
      #1;
      total++;
      if (bus.stall !== 1'b0) begin bad++; $display("FAIL rst_run_stall: got %b want 0", bus.stall); end
      @(posedge clk); #1;
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0)
         begin bad++; $display("FAIL rst_run_state: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
      total++;
      if (bus.result !== 32'd0 || bus.overflow !== 1'b0)
         begin bad++; $display("FAIL rst_run_out: got %h/%b want 0/0", bus.result, bus.overflow); end
      @(negedge clk);
      reset = 1'b0; bus.req = 1'b0; bus.flush = 1'b0;
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bus.req = 1'b1; bus.aluop = OP_MUL; bus.src1 = 32'd7; bus.src2 = 32'd6; bus.flush = 1'b0;
      repeat (32) @(negedge clk);
      #1;
      total++;
      if (bus.stall !== 1'b1) begin bad++; $display("FAIL b2b_last_run: got stall=%b want 1", bus.stall); end
      @(negedge clk);
      bus.src1 = 32'd3; bus.src2 = 32'd3;
      #1;
      total++;
      if (bus.done !== 1'b1 || bus.stall !== 1'b0 || bus.result !== 32'd42)
         begin bad++; $display("FAIL b2b_first_done: got done=%b stall=%b result=%h want 1 0 0000002a", bus.done, bus.stall, bus.result); end
      @(negedge clk); #1;
      total++;
      if (bus.stall !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0)
         begin bad++; $display("FAIL b2b_accept: got stall=%b busy=%b done=%b want 1 0 0", bus.stall, bus.busy, bus.done); end
      @(negedge clk);
      bus.req = 1'b0;
      #1;
      total++;
      if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_busy: got %b want 1", bus.busy); end
      repeat (32) @(negedge clk);
      #1;
      total++;
      if (bus.done !== 1'b1 || bus.result !== 32'd9)
         begin bad++; $display("FAIL b2b_second_done: got done=%b result=%h want 1 00000009", bus.done, bus.result); end
   endtask

   task automatic test_non_mul();
      @(negedge clk);
      bus.req = 1'b1; bus.aluop = OP_ADD; bus.src1 = 32'd1; bus.src2 = 32'd2; bus.flush = 1'b0;
      #1;
      total++;
      if (bus.stall !== 1'b0) begin bad++; $display("FAIL add_stall: got %b want 0", bus.stall); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         total++;
         if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.stall !== 1'b0)
            begin bad++; $display("FAIL add_idle%0d: got busy=%b done=%b stall=%b want 0 0 0", k, bus.busy, bus.done, bus.stall); end
      end
      total++;
      if (bus.result !== 32'd9) begin bad++; $display("FAIL add_result_hold: got %h want 00000009", bus.result); end
      bus.aluop = OP_MUL; bus.flush = 1'b1;
      #1;
      total++;
      if (bus.stall !== 1'b0) begin bad++; $display("FAIL idle_flush_stall: got %b want 0", bus.stall); end
      @(negedge clk); #1;
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_flush_busy: got %b want 0", bus.busy); end
      bus.req = 1'b0; bus.flush = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.req = 1'b0; bus.aluop = OP_ADD; bus.src1 = '0; bus.src2 = '0; bus.flush = 1'b0;
      test_reset();
      test_mul(32'd7, 32'd6, 32'd42, 1'b0, "mul_7x6");
      test_mul(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 1'b0, "mul_m3x5");
      test_mul(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "mul_min_x_m1");
      test_mul(32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, "mul_min_x_1");
      test_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, "mul_m1_x_m1");
      test_mul(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, "mul_2p16_sq");
      test_mul(32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 1'b0, "mul_max_x_1");
      test_flush();
      test_reset_mid_run();
      test_back_to_back();
      test_non_mul();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/exec_mul_ctrl.md
EXEC_MUL_CTRL -- requirements
Module: exec_mul_ctrl

Interface
REQ-001 Parameter REG_SIZE, default 32: operand and result width.
REQ-002 Parameter ALUOP_MUL, default `ALUOP_MUL: aluop code that selects a multiply.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 req  in  1  exec stage presents a valid instruction this cycle.
REQ-007 aluop  in  5  decoded ALU operation of the presented instruction.
REQ-008 src1  in  REG_SIZE  multiplicand, two's complement.
REQ-009 src2  in  REG_SIZE  multiplier, two's complement.
REQ-010 flush  in  1  abort in-flight operation (branch/exception squash).
REQ-011 stall  out  1  hold upstream pipeline registers.
REQ-012 busy  out  1  registered; high while state is RUN.
REQ-013 done  out  1  one-cycle pulse: result and overflow are valid.
REQ-014 result  out  REG_SIZE  low REG_SIZE bits of the signed product.
REQ-015 overflow  out  1  signed product does not fit in REG_SIZE bits.

Function
REQ-016 States: IDLE, RUN, DONE; the reset state is IDLE.
REQ-017 Accept condition: state IDLE, req=1, aluop=ALUOP_MUL, flush=0.
REQ-018 Requests with any other aluop are ignored: no state change and stall=0.
REQ-019 On accept, latch |src1|, |src2| and sign = src1[MSB] XOR src2[MSB]; clear the 2*REG_SIZE accumulator and the iteration counter; go to RUN.
REQ-020 RUN: one shift-add iteration per cycle, processing one multiplier bit LSB-first, for exactly REG_SIZE cycles; the counter is $clog2(REG_SIZE)+1 bits wide.
REQ-021 After the last iteration, go to DONE.
REQ-022 Output formation: the 2*REG_SIZE-bit magnitude product is negated when sign=1.
REQ-023 On entering DONE, register result as the low half of the product.
REQ-024 overflow = 1 iff the high half of the product differs from REG_SIZE copies of result[MSB].
REQ-025 Magnitude of -2^(REG_SIZE-1) is 2^(REG_SIZE-1), held in unsigned REG_SIZE bits; no loss.
REQ-026 DONE lasts exactly one cycle with done=1, then the state returns to IDLE.
REQ-027 A new request is accepted only in IDLE, never in DONE.
REQ-028 Latency: accept in cycle T; done=1 in cycle T+REG_SIZE+1 (33 cycles for REG_SIZE=32).
REQ-029 stall = (IDLE and accept condition) or RUN; it is combinational and is 0 in DONE, so the pipeline advances in the done cycle.
REQ-030 result and overflow hold their value from DONE until the next DONE; a flushed operation does not update them.
REQ-031 flush=1 in RUN: the next state is IDLE, no done pulse, and stall=0 in that cycle.
REQ-032 flush=1 in DONE: done still pulses; the consumer discards it.
REQ-033 flush=1 in IDLE together with a MUL req: not accepted.
REQ-034 src1 and src2 are sampled only at accept; changes during RUN have no effect.

Reset
REQ-035 reset=1 at a clock edge forces IDLE, busy=0, done=0, result=0, overflow=0, counter=0 and accumulator=0 regardless of state, including mid-RUN.
REQ-036 reset has priority over flush and req.
REQ-037 stall=0 while reset is asserted.

Verification
REQ-038 7 x 6 MUL accepted at T: stall=1 for T..T+32, done=1 only at T+33, result=42, overflow=0.
REQ-039 -3 x 5: result=0xFFFFFFF1, overflow=0; 0x80000000 x 0xFFFFFFFF: result=0x80000000, overflow=1.
REQ-040 0x00010000 x 0x00010000: result=0x00000000, overflow=1; 0x7FFFFFFF x 1: result=0x7FFFFFFF, overflow=0.
REQ-041 flush on the 10th RUN cycle: next state IDLE, no done, result keeps the prior value; a new MUL is accepted the following cycle.
REQ-042 reset mid-RUN: next cycle busy=0, result=0, overflow=0.
REQ-043 Back-to-back MUL req held high: second accept occurs the cycle after DONE.
REQ-044 req with ALUOP_ADD: stall=0 and no state change.
